otter_mem_arbiter: RTL and testbench
====================================

Name: otter_mem_arbiter

Overview:
- Shares one single-port synchronous program/data RAM between the otter_mcu instruction-fetch port and its data port.
- Arbitrates requests cycle by cycle and drives a single memory port that has 1-cycle read latency.
- Routes each read response back to the requester that issued it.
- Sits between otter_mcu and the unified memory, both in the riscof environment and in the SoC top.

Parameters:
- ADDR_W, 32, byte-address width of every port.
- DATA_PRIO, 1: 1 = data port has fixed priority on conflict; 0 = round-robin.
- MAX_STARVE, 4: with DATA_PRIO=1, the maximum number of consecutive lost conflicts for the fetch port before it is forced a grant. Range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held stable until granted.
- i_addr  in  ADDR_W  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid; pulses one cycle after i_gnt.
- i_rdata  out  32  fetch data; 0 when i_rvalid=0.
- d_req  in  1  data request; held stable until granted.
- d_we  in  1  1 = write, 0 = read.
- d_strb  in  4  write byte strobes.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response; pulses one cycle after d_gnt, for reads and writes (write ack).
- d_rdata  out  32  read data; 0 when d_rvalid=0 or the access was a write.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_strb  out  4  byte strobes; 4'b0000 on reads.
- mem_addr  out  ADDR_W  byte address forwarded unmodified.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.
- conflict_cnt  out  16  saturating count of cycles in which both ports requested.

Behaviour:
- Grant is combinational in the request cycle; at most one gnt per cycle. mem_* carries the granted request's fields in the same cycle.
- If no port is granted: mem_en=0 and mem_we=0, mem_strb=0, mem_addr=0, mem_wdata=0.
- With only one port requesting, that port is granted.
- Conflict, DATA_PRIO=1: the data port wins, unless starve_cnt==MAX_STARVE, in which case the fetch port wins.
  - starve_cnt increments on each lost fetch conflict.
  - starve_cnt clears whenever i_gnt=1.
  - starve_cnt holds when the fetch port is not requesting.
- Conflict, DATA_PRIO=0: the port not granted most recently wins. last_gnt updates on every grant and resets to FETCH, so the first conflict goes to DATA.
- Response register resp_owner in {NONE, FETCH, DATA_RD, DATA_WR} loads the grant type each cycle (NONE if no grant).
  - i_rvalid = (resp_owner==FETCH).
  - d_rvalid = (resp_owner==DATA_RD or DATA_WR).
  - rdata = mem_rdata only for FETCH and DATA_RD.
- Throughput: back-to-back grants allowed with no bubble; sustained 1 access per cycle.
- Write with d_strb=4'b0000: still granted and acked; memory contents are unchanged.
- conflict_cnt increments when i_req and d_req are both high with rst=0, and saturates at 16'hFFFF.
- Reset (synchronous, may arrive mid-operation): while rst=1 all gnt=0 and mem_en=0.
  - Next edge: resp_owner=NONE, starve_cnt=0, last_gnt=FETCH, conflict_cnt=0.
  - Therefore i_rvalid=d_rvalid=0 the cycle after rst is sampled; an in-flight response is dropped.
- Requests are not latched internally. A requester that deasserts req before gnt is simply not served.

Decomposition:
- Package otter_mem_pkg holds:
  - resp_owner enum (NONE, FETCH, DATA_RD, DATA_WR);
  - port-select enum (SEL_NONE, SEL_I, SEL_D);
  - constants STRB_W=4 and DATA_W=32.
- One sub-module, otter_mem_arb_pick. It is purely combinational: it takes i_req, d_req, DATA_PRIO, starve_cnt==MAX_STARVE and last_gnt, and returns the port select.
- Counters, response pipeline and muxing stay in otter_mem_arbiter.

Test Plan:
1. Fetch only: i_req=1 at 0x1000 for 3 cycles, memory word 0x00000013 -> i_gnt=1 each cycle, i_rvalid the following cycles with i_rdata=0x00000013, mem_en=1 continuously.
2. Write then read, data only: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_strb=4'b0011; next cycle read 0x2000 -> write ack d_rvalid with d_rdata=0, then read d_rdata=0x0000BEEF (memory pre-zeroed).
3. Starvation, DATA_PRIO=1, MAX_STARVE=4, both requesting continuously -> d_gnt 4 cycles, i_gnt on the 5th, then repeats; conflict_cnt=10 after 10 cycles.
4. Round-robin, DATA_PRIO=0, both requesting continuously from reset -> grants D,I,D,I...; each rvalid matches the prior grant owner.
5. Reset mid-read: d_gnt read at cycle N, rst=1 at cycle N+1 -> d_rvalid=0 at N+1, no gnt or mem_en while rst=1, conflict_cnt=0 after release.
6. Strobe-0 write: d_we=1, d_strb=0 at 0x3000 holding 0x12345678 -> acked; a subsequent read returns 0x12345678.

Source files
------------

// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types and widths for the otter_mcu fetch/data memory arbiter.
package otter_mem_pkg;

    localparam int STRB_W = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        NONE,
        FETCH,
        DATA_RD,
        DATA_WR
    } resp_owner_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_I,
        SEL_D
    } port_sel_t;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Fetch port, data port and unified memory port bundled for the arbiter.
interface otter_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    import otter_mem_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [STRB_W-1:0] d_strb;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [STRB_W-1:0] mem_strb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter's view: requests and memory read data come in.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_strb, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_strb, mem_addr, mem_wdata
    );

    // The requesters' and memory's view.
    modport master (
        output i_req, i_addr, d_req, d_we, d_strb, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_strb, mem_addr, mem_wdata
    );

endinterface

// File: rtl/otter_mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
module otter_mem_arb_pick
    import otter_mem_pkg::*;
#(
    parameter int DATA_PRIO = 1
) (
    input  logic      i_req,
    input  logic      d_req,
    input  logic      starved,
    input  port_sel_t last_gnt,
    output port_sel_t sel
);

    // On conflict: fixed data priority with a starvation escape, or round-robin.
    always_comb begin
        sel = SEL_NONE;
        if (i_req && d_req) begin
            if (DATA_PRIO != 0) begin
                sel = starved ? SEL_I : SEL_D;
            end else begin
                sel = (last_gnt == SEL_D) ? SEL_I : SEL_D;
            end
        end else if (i_req) begin
            sel = SEL_I;
        end else if (d_req) begin
            sel = SEL_D;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares one 1-cycle-latency memory port between otter_mcu fetch and data ports.
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_PRIO  = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                rst,
    otter_mem_arbiter_if.slave  bus,
    output logic [15:0]         conflict_cnt
);

    port_sel_t         pick_sel;
    port_sel_t         sel;
    port_sel_t         last_gnt;
    resp_owner_t       resp_owner;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              conflict;

    assign conflict = bus.i_req && bus.d_req;

    otter_mem_arb_pick #(
        .DATA_PRIO (DATA_PRIO)
    ) u_pick (
        .i_req    (bus.i_req),
        .d_req    (bus.d_req),
        .starved  (starve_cnt == 4'(MAX_STARVE)),
        .last_gnt (last_gnt),
        .sel      (pick_sel)
    );

    // Reset suppresses every grant combinationally, not just from the next edge.
    assign sel = rst ? SEL_NONE : pick_sel;

    always_comb begin
        sel_addr = '0;
        case (sel)
            SEL_I:   sel_addr = bus.i_addr;
            SEL_D:   sel_addr = bus.d_addr;
            default: sel_addr = '0;
        endcase
    end

    assign bus.i_gnt     = (sel == SEL_I);
    assign bus.d_gnt     = (sel == SEL_D);
    assign bus.mem_en    = (sel != SEL_NONE);
    assign bus.mem_we    = (sel == SEL_D) && bus.d_we;
    assign bus.mem_strb  = ((sel == SEL_D) && bus.d_we) ? bus.d_strb : '0;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = (sel == SEL_D) ? bus.d_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_owner   <= NONE;
            starve_cnt   <= '0;
            last_gnt     <= SEL_I;
            conflict_cnt <= '0;
        end else begin
            case (sel)
                SEL_I:   resp_owner <= FETCH;
                SEL_D:   resp_owner <= bus.d_we ? DATA_WR : DATA_RD;
                default: resp_owner <= NONE;
            endcase

            if (sel != SEL_NONE) begin
                last_gnt <= sel;
            end

            // Only a fetch that actually lost to data counts toward starvation.
            if (sel == SEL_I) begin
                starve_cnt <= '0;
            end else if (bus.i_req && sel == SEL_D) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (conflict && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    // A response still in flight when reset arrives is dropped immediately.
    assign bus.i_rvalid = !rst && (resp_owner == FETCH);
    assign bus.d_rvalid = !rst && (resp_owner == DATA_RD || resp_owner == DATA_WR);
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = (!rst && resp_owner == DATA_RD) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with identical stimulus, checked against a reference model.
module tb_otter_mem_arbiter;

    localparam int MAX_STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        t_rst    = 1'b1;
    logic        t_i_req  = 1'b0;
    logic [31:0] t_i_addr = '0;
    logic        t_d_req  = 1'b0;
    logic        t_d_we   = 1'b0;
    logic [3:0]  t_d_strb = '0;
    logic [31:0] t_d_addr = '0;
    logic [31:0] t_d_wdata = '0;

    logic [15:0] cnt0, cnt1;

    otter_mem_arbiter_if #(.ADDR_W(32)) bus0 ();
    otter_mem_arbiter_if #(.ADDR_W(32)) bus1 ();

    assign bus0.i_req = t_i_req;   assign bus1.i_req = t_i_req;
    assign bus0.i_addr = t_i_addr; assign bus1.i_addr = t_i_addr;
    assign bus0.d_req = t_d_req;   assign bus1.d_req = t_d_req;
    assign bus0.d_we = t_d_we;     assign bus1.d_we = t_d_we;
    assign bus0.d_strb = t_d_strb; assign bus1.d_strb = t_d_strb;
    assign bus0.d_addr = t_d_addr; assign bus1.d_addr = t_d_addr;
    assign bus0.d_wdata = t_d_wdata; assign bus1.d_wdata = t_d_wdata;

    otter_mem_arbiter #(.ADDR_W(32), .DATA_PRIO(1), .MAX_STARVE(MAX_STARVE)) dut0 (
        .clk(clk), .rst(t_rst), .bus(bus0), .conflict_cnt(cnt0)
    );
    otter_mem_arbiter #(.ADDR_W(32), .DATA_PRIO(0), .MAX_STARVE(MAX_STARVE)) dut1 (
        .clk(clk), .rst(t_rst), .bus(bus1), .conflict_cnt(cnt1)
    );

    logic [31:0] ram     [2][4096];
    logic [31:0] ref_mem [2][4096];

    function automatic logic [11:0] widx(input logic [31:0] a);
        return a[13:2];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Memories return garbage on non-read cycles so ungated rdata shows up.
    always @(posedge clk) begin
        if (bus0.mem_en && !bus0.mem_we) bus0.mem_rdata <= ram[0][widx(bus0.mem_addr)];
        else                             bus0.mem_rdata <= $urandom;
        if (bus0.mem_en && bus0.mem_we)
            ram[0][widx(bus0.mem_addr)] <= merge(ram[0][widx(bus0.mem_addr)], bus0.mem_wdata, bus0.mem_strb);
    end

    always @(posedge clk) begin
        if (bus1.mem_en && !bus1.mem_we) bus1.mem_rdata <= ram[1][widx(bus1.mem_addr)];
        else                             bus1.mem_rdata <= $urandom;
        if (bus1.mem_en && bus1.mem_we)
            ram[1][widx(bus1.mem_addr)] <= merge(ram[1][widx(bus1.mem_addr)], bus1.mem_wdata, bus1.mem_strb);
    end

    int num_checks = 0;
    int num_fails  = 0;

    int          starve     [2];
    int          last       [2];
    int          conf       [2];
    int          pend_owner [2];
    logic [31:0] pend_data  [2];
    int          prio       [2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner codes: 0 = none, 1 = fetch, 2 = data. Pending owner: 0 none, 1 fetch, 2 data read, 3 data write.
    task automatic checkBus(input int k);
        logic ig, dg, en, we, iv, dv;
        logic [3:0]  st;
        logic [31:0] ad, wd, ir, dr;
        logic [15:0] cc;
        int w;
        bit both;
        logic [31:0] exp_ir, exp_dr;
        bit exp_iv, exp_dv;
        if (k == 0) begin
            ig = bus0.i_gnt; dg = bus0.d_gnt; en = bus0.mem_en; we = bus0.mem_we;
            st = bus0.mem_strb; ad = bus0.mem_addr; wd = bus0.mem_wdata;
            iv = bus0.i_rvalid; ir = bus0.i_rdata; dv = bus0.d_rvalid; dr = bus0.d_rdata; cc = cnt0;
        end else begin
            ig = bus1.i_gnt; dg = bus1.d_gnt; en = bus1.mem_en; we = bus1.mem_we;
            st = bus1.mem_strb; ad = bus1.mem_addr; wd = bus1.mem_wdata;
            iv = bus1.i_rvalid; ir = bus1.i_rdata; dv = bus1.d_rvalid; dr = bus1.d_rdata; cc = cnt1;
        end

        both = t_i_req && t_d_req;
        if (t_rst)        w = 0;
        else if (both)    w = (prio[k] == 1) ? ((starve[k] == MAX_STARVE) ? 1 : 2)
                                             : ((last[k] == 2) ? 1 : 2);
        else if (t_i_req) w = 1;
        else if (t_d_req) w = 2;
        else              w = 0;

        checkOutput($sformatf("u%0d.i_gnt", k), 32'(ig), 32'(w == 1));
        checkOutput($sformatf("u%0d.d_gnt", k), 32'(dg), 32'(w == 2));
        checkOutput($sformatf("u%0d.mem_en", k), 32'(en), 32'(w != 0));
        checkOutput($sformatf("u%0d.mem_we", k), 32'(we), 32'(w == 2 && t_d_we));
        checkOutput($sformatf("u%0d.mem_strb", k), 32'(st), (w == 2 && t_d_we) ? 32'(t_d_strb) : 32'h0);
        checkOutput($sformatf("u%0d.mem_addr", k), ad, (w == 1) ? t_i_addr : (w == 2) ? t_d_addr : 32'h0);
        if (w == 2 && t_d_we) checkOutput($sformatf("u%0d.mem_wdata", k), wd, t_d_wdata);

        exp_iv = !t_rst && pend_owner[k] == 1;
        exp_dv = !t_rst && (pend_owner[k] == 2 || pend_owner[k] == 3);
        exp_ir = exp_iv ? pend_data[k] : 32'h0;
        exp_dr = (!t_rst && pend_owner[k] == 2) ? pend_data[k] : 32'h0;
        checkOutput($sformatf("u%0d.i_rvalid", k), 32'(iv), 32'(exp_iv));
        checkOutput($sformatf("u%0d.i_rdata", k), ir, exp_ir);
        checkOutput($sformatf("u%0d.d_rvalid", k), 32'(dv), 32'(exp_dv));
        checkOutput($sformatf("u%0d.d_rdata", k), dr, exp_dr);
        checkOutput($sformatf("u%0d.conflict_cnt", k), 32'(cc), 32'(conf[k]));

        // Advance the model to the state after the coming rising edge.
        if (t_rst) begin
            pend_owner[k] = 0; starve[k] = 0; last[k] = 1; conf[k] = 0;
        end else begin
            if (both && conf[k] < 65535) conf[k]++;
            if (w != 0) last[k] = w;
            if (w == 1) starve[k] = 0;
            else if (w == 2 && t_i_req) starve[k]++;
            if (w == 1) begin
                pend_owner[k] = 1; pend_data[k] = ref_mem[k][widx(t_i_addr)];
            end else if (w == 2 && !t_d_we) begin
                pend_owner[k] = 2; pend_data[k] = ref_mem[k][widx(t_d_addr)];
            end else if (w == 2) begin
                pend_owner[k] = 3; pend_data[k] = 32'h0;
                ref_mem[k][widx(t_d_addr)] = merge(ref_mem[k][widx(t_d_addr)], t_d_wdata, t_d_strb);
            end else begin
                pend_owner[k] = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [3:0] ds,
                                 input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        t_rst = r; t_i_req = ir; t_i_addr = ia;
        t_d_req = dr; t_d_we = dw; t_d_strb = ds; t_d_addr = da; t_d_wdata = dd;
        @(negedge clk);
        checkBus(0);
        checkBus(1);
    endtask

    initial begin
        prio[0] = 1; prio[1] = 0;
        for (int k = 0; k < 2; k++) begin
            starve[k] = 0; last[k] = 1; conf[k] = 0; pend_owner[k] = 0; pend_data[k] = '0;
            for (int a = 0; a < 4096; a++) begin
                ram[k][a] = '0; ref_mem[k][a] = '0;
            end
            ram[k][widx(32'h1000)] = 32'h0000_0013; ref_mem[k][widx(32'h1000)] = 32'h0000_0013;
            ram[k][widx(32'h3000)] = 32'h1234_5678; ref_mem[k][widx(32'h3000)] = 32'h1234_5678;
        end

        $display("[TB] reset");
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] fetch-only stream");
        repeat (3) applyStimulus(0, 1, 32'h1000, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] partial write then read back");
        applyStimulus(0, 0, 0, 1, 1, 4'b0011, 32'h2000, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 1, 0, 4'b0000, 32'h2000, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] zero-strobe write");
        applyStimulus(0, 0, 0, 1, 1, 4'b0000, 32'h3000, 32'hFFFF_FFFF);
        applyStimulus(0, 0, 0, 1, 0, 4'b0000, 32'h3000, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] continuous conflict from reset");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (12) applyStimulus(0, 1, 32'h1000, 1, 0, 0, 32'h2000, 0);

        $display("[TB] reset during read response");
        applyStimulus(0, 0, 0, 1, 0, 0, 32'h2000, 0);
        repeat (2) applyStimulus(1, 1, 32'h1000, 1, 0, 0, 32'h2000, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 9) < 7), 32'h2000 + (32'($urandom_range(0, 63)) << 2),
                          ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 32'h2000 + (32'($urandom_range(0, 63)) << 2),
                          $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
        $finish;
    end

endmodule
